// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm: debounce decision logic for one key or button.
// This block synchronizes btn_raw and runs the debounce counter through
// cnt_enable. It commits a level change only when cnt_zero reports that the
// wait has elapsed. It then drives a clean btn_level and one-cycle
// btn_press / btn_release strobes.
// Optional build macro KEY_DEBOUNCE_AUTOREPEAT_EN adds held-key autorepeat
// on btn_press, timed by REPEAT_DELAY and REPEAT_PERIOD.
module key_debounce_fsm #(
  parameter int               SYNC_STAGES   = 2,
  parameter int               RPT_W         = 24,
  parameter logic [RPT_W-1:0] REPEAT_DELAY  = 24'd5_000_000,
  parameter logic [RPT_W-1:0] REPEAT_PERIOD = 24'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic cnt_zero,
  output logic cnt_enable,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  // Reject configurations that cannot work: a single flop is not a synchronizer,
  // and a zero repeat interval would underflow the terminal-count compare.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("key_debounce_fsm: SYNC_STAGES must be at least 2");
  end
  if (REPEAT_DELAY == '0 || REPEAT_PERIOD == '0) begin : g_bad_rpt
    $error("key_debounce_fsm: REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
  end

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   press_d, release_d;
  logic                   press_q, release_q;
  logic                   rpt_hit;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchronizer chain for the asynchronous pad input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOW;
    else        state_q <= state_d;
  end

  // Next-state and commit decode. When the input reverts, that check comes
  // before the cnt_zero check, so a revert always wins over a commit.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      LOW: begin
        if (sync) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!sync) begin
          state_d = LOW;
        end else if (cnt_zero) begin
          state_d = HIGH;
          press_d = 1'b1;
        end
      end
      HIGH: begin
        if (!sync) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (sync) begin
          state_d = HIGH;
        end else if (cnt_zero) begin
          state_d   = LOW;
          release_d = 1'b1;
        end
      end
      default: state_d = LOW;
    endcase
  end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam logic [RPT_W-1:0] DELAY_LAST  = REPEAT_DELAY - 1'b1;
  localparam logic [RPT_W-1:0] PERIOD_LAST = REPEAT_PERIOD - 1'b1;

  logic [RPT_W-1:0] rpt_q;
  logic             rpt_first_q;

  // A repeat can fire only while the key is stably HIGH. It therefore never
  // lands on the same edge as a release, which is only issued from WAIT_LOW.
  assign rpt_hit = (state_q == HIGH) &&
                   (rpt_q == (rpt_first_q ? DELAY_LAST : PERIOD_LAST));

  // Autorepeat timer. It counts in HIGH and holds through a WAIT_LOW that may
  // abort back to HIGH. It clears in LOW/WAIT_HIGH, so it is 0 at every commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else if (state_q != HIGH && state_q != WAIT_LOW) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else if (rpt_hit) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b0;
    end else if (state_q == HIGH) begin
      rpt_q <= rpt_q + 1'b1;
    end
  end
`else
  assign rpt_hit = 1'b0;
`endif

  // Registered single-cycle strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= press_d | rpt_hit;
      release_q <= release_d;
    end
  end

  assign cnt_enable  = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
  assign btn_level   = (state_q == HIGH) || (state_q == WAIT_LOW);
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_key_debounce_fsm.sv
// Testbench for key_debounce_fsm.
// A small model of the debounce counter asserts cnt_zero after 4 enabled
// cycles. Expected strobe events (cycle and kind) are queued as each
// scenario is driven. A monitor pops and compares each strobe when the DUT
// emits it.
module tb_key_debounce_fsm;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic cnt_zero;
  logic cnt_enable;
  logic btn_level;
  logic btn_press;
  logic btn_release;

  logic force_zero;
  int   mc;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    int cyc;
    bit is_press;
  } ev_t;

  ev_t sb[$];

  key_debounce_fsm #(
    .SYNC_STAGES  (2),
    .RPT_W        (24),
    .REPEAT_DELAY (24'd10),
    .REPEAT_PERIOD(24'd3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .cnt_zero   (cnt_zero),
    .cnt_enable (cnt_enable),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // Posedge counter used to timestamp events
  always @(posedge clk) cyc <= cyc + 1;

  // Debounce counter model: counts enabled cycles, flags zero after 4
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           mc <= 0;
    else if (!cnt_enable) mc <= 0;
    else if (mc < 4)      mc <= mc + 1;
  end
  assign cnt_zero = (mc == 4) | force_zero;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic push_ev(input int c, input bit p);
    ev_t e;
    e.cyc      = c;
    e.is_press = p;
    sb.push_back(e);
  endtask

  // Strobe monitor: compare each emitted strobe against the next expected event
  always @(negedge clk) begin
    ev_t e;
    if (btn_press || btn_release) begin
      if (btn_press && btn_release) check("strobe_exclusive", 1, 0);
      if (sb.size() == 0) begin
        check("unexpected_strobe_cycle", cyc, -1);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_is_press", int'(btn_press), int'(e.is_press));
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    btn_raw    = 1'b1;
    force_zero = 1'b0;

    // Reset held with the key pressed: everything idle
    wait_to(3);
    check("rst_enable",  cnt_enable,  0);
    check("rst_level",   btn_level,   0);
    check("rst_press",   btn_press,   0);
    check("rst_release", btn_release, 0);
    rst_n = 1'b1;
    push_ev(11, 1'b1);           // 2 sync + 1 entry + 4 count + 1 commit
    wait_to(10);
    check("press_wait_enable", cnt_enable, 1);
    check("press_wait_level",  btn_level,  0);
    wait_to(11);
    check("press_commit_level",  btn_level,  1);
    check("press_commit_enable", cnt_enable, 0);

    // Clean release from HIGH
    wait_to(13);
    btn_raw = 1'b0;
    push_ev(21, 1'b0);
    wait_to(20);
    check("rel_wait_enable", cnt_enable, 1);
    check("rel_wait_level",  btn_level,  1);
    wait_to(21);
    check("rel_commit_level", btn_level, 0);
    wait_to(23);
    check("rel_after_enable", cnt_enable, 0);

    // Bounce: two raw-high cycles give a two-cycle enable pulse, no strobe
    btn_raw = 1'b1;
    wait_to(25);
    btn_raw = 1'b0;
    wait_to(26);
    check("bounce_enable_a", cnt_enable, 1);
    wait_to(27);
    check("bounce_enable_b", cnt_enable, 1);
    check("bounce_level",    btn_level,  0);
    wait_to(28);
    check("bounce_enable_off", cnt_enable, 0);
    check("bounce_level_off",  btn_level,  0);

    // Race: cnt_zero on the same edge the synced input reverts
    wait_to(33);
    btn_raw = 1'b1;
    wait_to(35);
    btn_raw = 1'b0;
    wait_to(37);
    check("race_in_wait", cnt_enable, 1);
    force_zero = 1'b1;
    wait_to(38);
    force_zero = 1'b0;
    check("race_level",  btn_level,  0);
    check("race_enable", cnt_enable, 0);
    wait_to(40);
    check("race_level_late", btn_level, 0);

    // Mid-wait reset: press, start releasing, reset inside WAIT_LOW
    wait_to(43);
    btn_raw = 1'b1;
    push_ev(51, 1'b1);
    wait_to(55);
    btn_raw = 1'b0;
    wait_to(60);
    check("midrst_wait_enable", cnt_enable, 1);
    check("midrst_wait_level",  btn_level,  1);
    rst_n = 1'b0;
    #1;
    check("midrst_async_level",  btn_level,  0);
    check("midrst_async_enable", cnt_enable, 0);
    check("midrst_async_press",  btn_press,  0);
    wait_to(63);
    rst_n = 1'b1;
    wait_to(70);
    check("midrst_after_level",  btn_level,  0);
    check("midrst_after_enable", cnt_enable, 0);

    // Held key: commit, then autorepeats when built with the feature
    wait_to(73);
    btn_raw = 1'b1;
    push_ev(81, 1'b1);
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    push_ev(91, 1'b1);
    push_ev(94, 1'b1);
    push_ev(97, 1'b1);
`endif
    wait_to(96);
    btn_raw = 1'b0;
    push_ev(104, 1'b0);
    wait_to(100);
    check("hold_rel_wait_enable", cnt_enable, 1);
    check("hold_rel_wait_level",  btn_level,  1);
    wait_to(104);
    check("hold_rel_level", btn_level, 0);
    wait_to(115);
    check("hold_final_enable", cnt_enable, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_debounce_fsm.md
# key_debounce_fsm

Debounce controller for one synthesizer key or button. Synchronizes the raw pad input, drives the enable of the external debounce counter and consumes its zero flag, and produces a clean debounced level plus single-cycle press/release strobes for the note-select logic downstream. The block is the state-holding partner of the debounce counter: the counter only times, and this block decides.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flop count on btn_raw, minimum 2.
- RPT_W, 24: width of the autorepeat cycle counter.
- REPEAT_DELAY, 24'd5_000_000: clocks from a committed press to the first repeat strobe.
- REPEAT_PERIOD, 24'd1_000_000: clocks between subsequent repeat strobes.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_raw  in  1  asynchronous pad input, 1 = pressed.
- cnt_zero  in  1  zero flag from the debounce counter.
- cnt_enable  out  1  enable to the debounce counter; low reloads it.
- btn_level  out  1  debounced level.
- btn_press  out  1  one-cycle strobe on committed press (and repeats).
- btn_release  out  1  one-cycle strobe on committed release.

## Operation
- Synchronizer: SYNC_STAGES-deep shift register; its last stage is `sync`. All stages reset to 0.
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW. Reset state LOW.
  - LOW: sync==1 → WAIT_HIGH; else stay.
  - WAIT_HIGH: sync==0 → LOW (abort, no strobe); else cnt_zero==1 → HIGH with btn_press; else stay.
  - HIGH: sync==0 → WAIT_LOW; else stay.
  - WAIT_LOW: sync==1 → HIGH (abort, no strobe); else cnt_zero==1 → LOW with btn_release; else stay.
- cnt_enable = 1 exactly while in WAIT_HIGH or WAIT_LOW (decoded from the state register, no combinational path from inputs). Every abort or commit therefore drops enable, and the counter reloads before the next wait.
- cnt_zero is ignored in LOW and HIGH.
- Simultaneous sync revert and cnt_zero in a WAIT state: the revert wins; return to the prior stable state with no strobe.
- btn_level = 1 in HIGH and WAIT_LOW, 0 in LOW and WAIT_HIGH. It changes only on commits.
- btn_press and btn_release are registered, high for exactly one cycle, and never high together.

## Timing
- Reset values: cnt_enable=0, btn_level=0, btn_press=0, btn_release=0, all synchronizer stages 0, repeat counter 0.
- Raw to sync latency: SYNC_STAGES cycles.
- WAIT entry: one edge after sync changes, so cnt_enable rises on that edge.
- Commit: on the first edge where the FSM is in a WAIT state, sync is at the new level and cnt_zero==1. btn_level and the strobe update on that same edge, and cnt_enable falls on that same edge.
- Total press latency = SYNC_STAGES + 1 + (counter run length) + 1 cycles.
- Reset may assert mid-wait. All outputs clear immediately, with no strobe.

## Configuration
- KEY_DEBOUNCE_AUTOREPEAT_EN defined:
  - While in HIGH, the RPT_W-bit counter increments every cycle.
  - It is cleared on the commit to HIGH and whenever the FSM is not in HIGH or WAIT_LOW. It holds its value in WAIT_LOW.
  - When it reaches REPEAT_DELAY-1 (first repeat) or REPEAT_PERIOD-1 (later repeats), btn_press strobes for one cycle and the counter restarts at 0.
  - A repeat never coincides with btn_release.
- KEY_DEBOUNCE_AUTOREPEAT_EN undefined: no repeat counter exists. btn_press fires only on a committed press, and the REPEAT_* parameters are unused.

## Test plan
Bench model of the counter: cnt_zero=1 after 4 consecutive enabled cycles, cleared when enable drops. SYNC_STAGES=2.
- Reset: rst_n=0 with btn_raw=1 → all outputs 0. Release reset → btn_press at cycle 2+1+4+1=8, btn_level=1 from that cycle.
- Bounce: btn_raw high for 2 cycles, then low → cnt_enable pulses for 2 cycles, no strobe, btn_level stays 0.
- Release: from HIGH, btn_raw=0 held → exactly one btn_release, btn_level=0, cnt_enable low afterwards.
- Race: force cnt_zero=1 on the same edge that sync reverts in WAIT_HIGH → state returns to LOW, no btn_press.
- Mid-wait reset: assert rst_n=0 while in WAIT_LOW → btn_level=0 asynchronously, no btn_release ever emitted.
- Autorepeat (macro on, REPEAT_DELAY=10, REPEAT_PERIOD=3): hold the key → press strobes at commit, +10, +13, +16. On release, the repeats stop and one btn_release fires.
